// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered integer-pipeline instruction decoder. Decodes R-type and I-type
// ALU encodings (including XLEN-dependent immediate shifts), flags every
// unsupported encoding as illegal, and holds the result in a one-entry
// valid/ready output register with backpressure and flush.
//
// Optional feature macro: DECODE_MEXT_EN
//   defined   - R-type funct7=0000001 decodes the M extension (codes 10..17)
//   undefined - those encodings are flagged illegal
//
// Parameters:
//   XLEN     - datapath width, 32 or 64 (immediate and shamt width)
//   ALU_OP_W - alu_op width, at least 5
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   flush          - drop the held entry and any entry accepted this cycle
//   in_valid/in_ready/in_instr - upstream handshake and instruction word
//   out_valid/out_ready        - downstream handshake
//   out_rd, out_rs1, out_rs2   - register fields (rs2 is 0 for I-type)
//   out_imm, out_use_imm       - operand-B immediate and its select
//   out_alu_op, out_reg_write, out_illegal - decoded control
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [XLEN-1:0]     out_imm,
    output logic                out_use_imm,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic                out_reg_write,
    output logic                out_illegal
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(9);
`ifdef DECODE_MEXT_EN
    localparam logic [ALU_OP_W-1:0] OP_MUL  = ALU_OP_W'(10);
`endif

    typedef struct packed {
        logic [4:0]          rs2;
        logic [XLEN-1:0]     imm;
        logic                use_imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic                legal;
    } dec_t;

    function automatic logic signed [XLEN-1:0] sext_imm12(input logic [11:0] imm12);
        logic signed [XLEN-1:0] res;
        res = {{(XLEN-12){imm12[11]}}, imm12};
        return res;
    endfunction

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] opcode;
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic [5:0] shamt;
        logic       sh_plain;  // upper bits all zero (SLLI/SRLI)
        logic       sh_arith;  // upper bits mark SRAI
        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];
        // RV64 steals instr[25] for shamt[5], so the check field shrinks by one bit.
        if (XLEN == 64) begin
            shamt    = instr[25:20];
            sh_plain = (instr[31:26] == 6'b000000);
            sh_arith = (instr[31:26] == 6'b010000);
        end else begin
            shamt    = {1'b0, instr[24:20]};
            sh_plain = (instr[31:25] == 7'b0000000);
            sh_arith = (instr[31:25] == 7'b0100000);
        end
        d.rs2     = instr[24:20];
        d.imm     = '0;
        d.use_imm = 1'b0;
        d.alu_op  = OP_ADD;
        d.legal   = 1'b0;
        case (opcode)
            OPC_R: begin
                case (funct7)
                    7'b0000000: begin
                        d.legal = 1'b1;
                        case (funct3)
                            3'd0:    d.alu_op = OP_ADD;
                            3'd1:    d.alu_op = OP_SLL;
                            3'd2:    d.alu_op = OP_SLT;
                            3'd3:    d.alu_op = OP_SLTU;
                            3'd4:    d.alu_op = OP_XOR;
                            3'd5:    d.alu_op = OP_SRL;
                            3'd6:    d.alu_op = OP_OR;
                            default: d.alu_op = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'd0) begin
                            d.alu_op = OP_SUB;
                            d.legal  = 1'b1;
                        end else if (funct3 == 3'd5) begin
                            d.alu_op = OP_SRA;
                            d.legal  = 1'b1;
                        end
                    end
`ifdef DECODE_MEXT_EN
                    7'b0000001: begin
                        d.alu_op = OP_MUL + ALU_OP_W'(funct3);
                        d.legal  = 1'b1;
                    end
`endif
                    default: d.legal = 1'b0;
                endcase
            end
            OPC_I: begin
                d.rs2     = 5'd0;
                d.use_imm = 1'b1;
                d.imm     = sext_imm12(instr[31:20]);
                d.legal   = 1'b1;
                case (funct3)
                    3'd0: d.alu_op = OP_ADD;
                    3'd2: d.alu_op = OP_SLT;
                    3'd3: d.alu_op = OP_SLTU;
                    3'd4: d.alu_op = OP_XOR;
                    3'd6: d.alu_op = OP_OR;
                    3'd7: d.alu_op = OP_AND;
                    3'd1: begin
                        d.alu_op = OP_SLL;
                        d.imm    = {{(XLEN-6){1'b0}}, shamt};
                        d.legal  = sh_plain;
                    end
                    default: begin
                        d.alu_op = sh_arith ? OP_SRA : OP_SRL;
                        d.imm    = {{(XLEN-6){1'b0}}, shamt};
                        d.legal  = sh_plain || sh_arith;
                    end
                endcase
            end
            default: d.legal = 1'b0;
        endcase
        // Illegal entries carry only the raw register fields downstream.
        if (!d.legal) begin
            d.alu_op  = OP_ADD;
            d.use_imm = 1'b0;
            d.imm     = '0;
        end
        return d;
    endfunction

    dec_t dec_p0;
    logic accept_p0;

    logic                vld_p1;
    logic [4:0]          rd_p1;
    logic [4:0]          rs1_p1;
    logic [4:0]          rs2_p1;
    logic [XLEN-1:0]     imm_p1;
    logic                use_imm_p1;
    logic [ALU_OP_W-1:0] alu_op_p1;
    logic                reg_write_p1;
    logic                illegal_p1;

    assign dec_p0    = decode(in_instr);
    assign in_ready  = !vld_p1 || out_ready;
    assign accept_p0 = in_valid && in_ready;

    // ---- stage p0 -> p1: decoded instruction into the output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            rd_p1        <= '0;
            rs1_p1       <= '0;
            rs2_p1       <= '0;
            imm_p1       <= '0;
            use_imm_p1   <= 1'b0;
            alu_op_p1    <= '0;
            reg_write_p1 <= 1'b0;
            illegal_p1   <= 1'b0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (accept_p0) begin
                vld_p1 <= 1'b1;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (accept_p0 && !flush) begin
                rd_p1        <= in_instr[11:7];
                rs1_p1       <= in_instr[19:15];
                rs2_p1       <= dec_p0.rs2;
                imm_p1       <= dec_p0.imm;
                use_imm_p1   <= dec_p0.use_imm;
                alu_op_p1    <= dec_p0.alu_op;
                reg_write_p1 <= dec_p0.legal && (in_instr[11:7] != 5'd0);
                illegal_p1   <= !dec_p0.legal;
            end
        end
    end

    assign out_valid     = vld_p1;
    assign out_rd        = rd_p1;
    assign out_rs1       = rs1_p1;
    assign out_rs2       = rs2_p1;
    assign out_imm       = imm_p1;
    assign out_use_imm   = use_imm_p1;
    assign out_alu_op    = alu_op_p1;
    assign out_reg_write = reg_write_p1;
    assign out_illegal   = illegal_p1;

endmodule
